// File: rtl/split_merge_pkg.sv
// Shared FSM state encoding and default sizing for the split-result merger.
package split_merge_pkg;

   localparam int DEF_NSPLIT     = 8;
   localparam int DEF_TAG_W      = 16;
   localparam int DEF_CNT_W      = 32;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } merge_state_e;

endpackage

// File: rtl/split_tag_fifo.sv
// Accepted-tag buffer: synchronous FIFO with flop-sourced head output and full/empty flags.
module split_tag_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/split_result_merger.sv
// Merges per-split constraint bits into accept/reject decisions and buffers accepted tags.
// Optional statistics (reject_cnt, first_fail) are built only with SPLIT_MERGE_STATS_EN defined.
module split_result_merger
   import split_merge_pkg::*;
#(
   parameter int NSPLIT     = DEF_NSPLIT,
   parameter int TAG_W      = DEF_TAG_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [CNT_W-1:0]          target_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [TAG_W-1:0]          in_tag,
   input  logic [NSPLIT-1:0]         in_x,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [TAG_W-1:0]          out_tag,
   output logic [CNT_W-1:0]          accept_cnt,
   output logic [CNT_W-1:0]          reject_cnt,
   output logic [$clog2(NSPLIT)-1:0] first_fail,
   output logic                      done
);

   localparam int FF_W = $clog2(NSPLIT);

   merge_state_e     state, state_nx;
   logic [CNT_W-1:0] target_q, accept_inc;
   logic             fifo_full, fifo_empty;
   logic             xfer, pass, push, pop, start_take;

   assign in_ready   = (state == ST_RUN) && !fifo_full;
   assign xfer       = in_valid && in_ready;
   assign pass       = &in_x;
   assign push       = xfer && pass;
   assign out_valid  = !fifo_empty;
   assign pop        = out_valid && out_ready;
   assign done       = (state == ST_DRAIN) && fifo_empty;
   assign start_take = start && (state != ST_RUN);
   assign accept_inc = (accept_cnt == '1) ? accept_cnt : accept_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // NOTE: next-state takes its default first so no path through the case leaves it unassigned.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DRAIN: if (start) state_nx = (target_n == '0) ? ST_DRAIN : ST_RUN;
         ST_RUN:            if (push && (accept_inc == target_q)) state_nx = ST_DRAIN;
         default:           state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         accept_cnt <= '0;
         target_q   <= '0;
      end else if (start_take) begin
         accept_cnt <= '0;
         target_q   <= target_n;
      end else if (push) begin
         accept_cnt <= accept_inc;
      end
   end

`ifdef SPLIT_MERGE_STATS_EN
   logic [FF_W-1:0] fail_idx;

   // Scan from the top so the lowest cleared bit wins.
   always_comb begin
      fail_idx = '0;
      for (int i = NSPLIT - 1; i >= 0; i--) begin
         if (!in_x[i]) fail_idx = FF_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reject_cnt <= '0;
         first_fail <= '0;
      end else if (start_take) begin
         reject_cnt <= '0;
      end else if (xfer && !pass) begin
         if (reject_cnt != '1) reject_cnt <= reject_cnt + CNT_W'(1);
         first_fail <= fail_idx;
      end
   end
`else
   assign reject_cnt = '0;
   assign first_fail = '0;
`endif

   split_tag_fifo #(
      .W     (TAG_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (in_tag),
      .pop   (pop),
      .dout  (out_tag),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_split_result_merger.sv
// Scoreboard bench for split_result_merger: a driver queues expected tags, a monitor pops and compares.
module tb_split_result_merger;

   localparam int NSPLIT = 8;
   localparam int TAG_W  = 16;
   localparam int CNT_W  = 32;
   localparam int DEPTH  = 4;
`ifdef SPLIT_MERGE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, start, in_valid, out_ready;
   logic [CNT_W-1:0]  target_n;
   logic [TAG_W-1:0]  in_tag;
   logic [NSPLIT-1:0] in_x;
   logic              in_ready, out_valid, done;
   logic [TAG_W-1:0]  out_tag;
   logic [CNT_W-1:0]  accept_cnt, reject_cnt;
   logic [2:0]        first_fail;

   int checks = 0;
   int errors = 0;
   logic [TAG_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   split_result_merger #(
      .NSPLIT(NSPLIT), .TAG_W(TAG_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .target_n(target_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .accept_cnt(accept_cnt), .reject_cnt(reject_cnt), .first_fail(first_fail),
      .done(done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake on the output side must match the oldest expected tag.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out_tag", 64'(out_tag), 64'hFFFF_FFFF);
         else                   check("out_tag_order", 64'(out_tag), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start    = 1'b1;
      target_n = n;
      step();
      start    = 1'b0;
   endtask

   // Offer one candidate and hold it until accepted; queues the tag if all split bits pass.
   task automatic send(input logic [TAG_W-1:0] tag, input logic [NSPLIT-1:0] x);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_tag   = tag;
      in_x     = x;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) check("send_timeout", 64'(in_ready), 64'd1);
      else if (&x) exp_q.push_back(tag);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         if (done) seen = 1'b1;
      end
      check("wait_done", 64'(seen), 64'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; target_n = '0;
      in_valid = 1'b0; in_tag = '0; in_x = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // Reset state
      check("rst_in_ready",   64'(in_ready),   64'd0);
      check("rst_out_valid",  64'(out_valid),  64'd0);
      check("rst_done",       64'(done),       64'd0);
      check("rst_accept_cnt", 64'(accept_cnt), 64'd0);
      check("rst_reject_cnt", 64'(reject_cnt), 64'd0);
      check("rst_first_fail", 64'(first_fail), 64'd0);

      // Target 3, five offered candidates: only tags 0..2 get in
      out_ready = 1'b1;
      do_start(3);
      for (int t = 0; t < 3; t++) send(TAG_W'(t), 8'hFF);
      check("t1_in_ready_low", 64'(in_ready),   64'd0);
      check("t1_accept_cnt",   64'(accept_cnt), 64'd3);
      check("t1_done_not_yet", 64'(done),       64'd0);
      in_valid = 1'b1; in_tag = 16'd3; in_x = 8'hFF;
      step();
      check("t1_done_after_pop", 64'(done),     64'd1);
      check("t1_in_ready_drain", 64'(in_ready), 64'd0);
      in_tag = 16'd4;
      step();
      check("t1_accept_hold", 64'(accept_cnt), 64'd3);
      in_valid = 1'b0;

      // Rejects: first failing split index and counters
      do_start(5);
      send(16'h00A0, 8'hFB);
      check("rej1_accept_cnt", 64'(accept_cnt), 64'd0);
      check("rej1_reject_cnt", 64'(reject_cnt), STATS ? 64'd1 : 64'd0);
      check("rej1_first_fail", 64'(first_fail), STATS ? 64'd2 : 64'd0);
      check("rej1_no_push",    64'(out_valid),  64'd0);
      send(16'h00A1, 8'h7F);
      check("rej2_first_fail", 64'(first_fail), STATS ? 64'd7 : 64'd0);
      send(16'h00A2, 8'h00);
      check("rej3_reject_cnt", 64'(reject_cnt), STATS ? 64'd3 : 64'd0);
      check("rej3_first_fail", 64'(first_fail), STATS ? 64'd0 : 64'd0);

      // Backpressure: fill the buffer, hold the head, release one slot
      out_ready = 1'b0;
      for (int t = 0; t < DEPTH; t++) send(TAG_W'(16'h10 + t), 8'hFF);
      check("bp_in_ready_full", 64'(in_ready),  64'd0);
      check("bp_out_tag_head",  64'(out_tag),   64'h10);
      step(); step();
      check("bp_out_tag_hold",  64'(out_tag),   64'h10);
      check("bp_out_valid",     64'(out_valid), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_in_ready_free", 64'(in_ready),  64'd1);
      out_ready = 1'b1;
      send(16'h14, 8'hFF);
      wait_done();
      check("bp_accept_cnt", 64'(accept_cnt), 64'd5);

      // Zero target: straight to drain, nothing accepted
      do_start(0);
      check("z_done",     64'(done),     64'd1);
      check("z_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_tag = 16'h55; in_x = 8'hFF;
      step(); step();
      check("z_accept_cnt", 64'(accept_cnt), 64'd0);
      check("z_out_valid",  64'(out_valid),  64'd0);
      in_valid = 1'b0;

      // Reset mid-run with two tags buffered; reset wins over a same-cycle start
      out_ready = 1'b0;
      do_start(10);
      send(16'h31, 8'hFF);
      send(16'h32, 8'hFF);
      step();
      rst = 1'b1; start = 1'b1; target_n = 32'd4;
      exp_q.delete();
      step();
      rst = 1'b0; start = 1'b0;
      check("mr_out_valid",  64'(out_valid),  64'd0);
      check("mr_accept_cnt", 64'(accept_cnt), 64'd0);
      check("mr_reject_cnt", 64'(reject_cnt), 64'd0);
      check("mr_idle",       64'(in_ready),   64'd0);
      check("mr_done",       64'(done),       64'd0);

      out_ready = 1'b1;
      do_start(1);
      send(16'h77, 8'hFF);
      wait_done();
      check("post_accept_cnt", 64'(accept_cnt), 64'd1);
      step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/split_result_merger.md
SPLIT_RESULT_MERGER -- requirements
Module: split_result_merger

Interface
- REQ-001: Parameter NSPLIT, default 8: number of split-constraint result bits merged per candidate.
- REQ-002: Parameter TAG_W, default 16: width of the candidate tag.
- REQ-003: Parameter CNT_W, default 32: width of the counters and of target_n.
- REQ-004: Parameter FIFO_DEPTH, default 4 (power of two, >=2): number of accepted-tag buffer entries.
- REQ-005: clk  input  1  single clock; all state updates on the rising edge.
- REQ-006: rst  input  1  synchronous, active-high reset.
- REQ-007: start  input  1  one-cycle pulse that begins a run.
- REQ-008: target_n  input  CNT_W  number of accepted candidates that ends the run; sampled on start.
- REQ-009: in_valid  input  1  candidate result present.
- REQ-010: in_ready  output  1  merger accepts a candidate this cycle.
- REQ-011: in_tag  input  TAG_W  candidate identifier.
- REQ-012: in_x  input  NSPLIT  per-split constraint outputs (x of each split_N) for this candidate.
- REQ-013: out_valid  output  1  accepted tag available.
- REQ-014: out_ready  input  1  consumer takes the tag.
- REQ-015: out_tag  output  TAG_W  tag of the accepted candidate.
- REQ-016: accept_cnt  output  CNT_W  accepted candidates in the current run.
- REQ-017: reject_cnt  output  CNT_W  rejected candidates in the current run (stats build only).
- REQ-018: first_fail  output  $clog2(NSPLIT)  lowest failing split index of the most recent reject (stats build only).
- REQ-019: done  output  1  run complete and buffer drained.

Function
- REQ-020: FSM states: IDLE, RUN, DRAIN; reset state is IDLE.
- REQ-021: IDLE or DRAIN with start=1 -> counters cleared, target latched, FIFO content retained; go to RUN, or to DRAIN if target_n==0.
- REQ-022: start in RUN is ignored.
- REQ-023: in_ready = (state==RUN) && FIFO not full; no same-cycle full bypass.
- REQ-024: Transfer = in_valid && in_ready; candidate passes iff &in_x == 1.
- REQ-025: Pass -> in_tag pushed to FIFO, accept_cnt incremented; fail -> reject_cnt incremented, first_fail updated.
- REQ-026: Pushed tag is visible on out_valid/out_tag the cycle after the transfer (1-cycle latency); FIFO order preserved.
- REQ-027: Pop = out_valid && out_ready; push and pop in the same cycle are both honoured.
- REQ-028: Pass transfer that makes accept_cnt equal to the latched target -> DRAIN next cycle; no further transfers.
- REQ-029: done = (state==DRAIN) && FIFO empty; done stays high until start or rst.
- REQ-030: Counters saturate at all-ones and never wrap; out_tag holds its value while out_valid=1 and out_ready=0.

Reset
- REQ-031: rst -> IDLE; FIFO flushed; accept_cnt, reject_cnt, first_fail = 0; in_ready, out_valid, done = 0.
- REQ-032: rst mid-run discards buffered tags; rst has priority over start and transfers in the same cycle.

Configuration
- REQ-033: With SPLIT_MERGE_STATS_EN defined, reject_cnt and first_fail are implemented as in REQ-025.
- REQ-034: Without SPLIT_MERGE_STATS_EN, reject_cnt and first_fail are tied to 0 and no stats registers exist; all other behaviour is unchanged.

Structure
- REQ-035: Package split_merge_pkg holds the FSM state enum and the default parameter constants.
- REQ-036: The tag buffer is one sub-module, split_tag_fifo (synchronous, registered output, full/empty flags).

Verification
- REQ-037: target_n=3, five candidates with all in_x=1, out_ready=1 -> tags 0,1,2 out in order; accept_cnt=3; in_ready low after the third transfer; done one cycle after the last pop.
- REQ-038: NSPLIT=8, in_x=8'hFB -> no push; reject_cnt=1; first_fail=2 (stats build); accept_cnt unchanged.
- REQ-039: out_ready=0 with FIFO_DEPTH=4 -> after 4 passes, in_ready=0; raising out_ready for 1 cycle -> in_ready=1 next cycle.
- REQ-040: start with target_n=0 -> DRAIN with done=1 next cycle; no transfers occur.
- REQ-041: rst asserted with 2 tags buffered in RUN -> next cycle out_valid=0, counters=0, state IDLE; a subsequent start runs cleanly.
